// File: rtl/dac_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dac_frame_tx_pkg
// Brief   : Shared frame geometry and FSM state encoding for the DAC SPI TX.
// Revision: 1.0 - initial release
// ============================================================================
package dac_frame_tx_pkg;

  localparam int DDS_DATA_W  = 12;
  localparam int DDS_FRAME_W = 16;
  localparam int PD_LSB      = 12;
  localparam int PD_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : dac_frame_tx_if
// Brief   : Sample bus from the output mux: sample word, power-down bits, strobe.
// Revision: 1.0 - initial release
// ============================================================================
interface dac_frame_tx_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_stb;
  logic [1:0]        pd_in;

  modport master (output sample_in, output sample_stb, output pd_in);
  modport slave  (input  sample_in, input  sample_stb, input  pd_in);
endinterface
`default_nettype wire

// File: rtl/dac_frame_tx_spi_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : dac_frame_tx_spi_bit_timer
// Brief   : Divides clk into sclk half-periods; ticks on the last clk of each.
// Revision: 1.0 - initial release
// ============================================================================
module dac_frame_tx_spi_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic run,
  output logic      rise_tick,
  output logic      fall_tick
);

  localparam int c_div_w = $clog2(2 * CLK_DIV);
  localparam logic [c_div_w-1:0] c_rise = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_last = c_div_w'(2 * CLK_DIV - 1);

  logic [c_div_w-1:0] div_cnt_q, div_cnt_d;

  // Held at zero outside SHIFT so every frame starts on a fresh low phase.
  always_comb begin
    div_cnt_d = '0;
    if (run) begin
      div_cnt_d = (div_cnt_q == c_last) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign rise_tick = run && (div_cnt_q == c_rise);
  assign fall_tick = run && (div_cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/dac_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : dac_frame_tx
// Brief   : Newest-wins sample holding register feeding a 16-bit SPI DAC writer.
// Revision: 1.0 - initial release
// ============================================================================
module dac_frame_tx
  import dac_frame_tx_pkg::*;
#(
  parameter int DATA_W  = DDS_DATA_W,
  parameter int FRAME_W = DDS_FRAME_W,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2,
  parameter int OVR_W   = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en,
  input  wire logic        clr_ovr,
  dac_frame_tx_if.slave    smp,
  output logic             sclk,
  output logic             mosi,
  output logic             csb,
  output logic             busy,
  output logic             hold_full,
  output logic [OVR_W-1:0] ovr_cnt
);

  localparam int c_bit_w = $clog2(FRAME_W);
  localparam int c_gap_w = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(FRAME_W - 1);
  localparam logic [c_gap_w-1:0] c_last_gap = c_gap_w'(CS_GAP - 1);
  localparam logic [OVR_W-1:0]   c_ovr_max  = {OVR_W{1'b1}};

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [OVR_W-1:0]     ovr_q, ovr_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [c_bit_w-1:0]   bit_cnt_q, bit_cnt_d;
  logic [c_gap_w-1:0]   gap_cnt_q, gap_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 csb_q, csb_d;

  logic [FRAME_W-1:0]   w_frame_in;
  logic                 w_drain;
  logic                 w_rise_tick;
  logic                 w_fall_tick;

  dac_frame_tx_spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state_q == ST_SHIFT),
    .rise_tick (w_rise_tick),
    .fall_tick (w_fall_tick)
  );

  assign w_drain = (state_q == ST_IDLE) && en && hold_full_q;

  always_comb begin
    w_frame_in                   = '0;
    w_frame_in[DATA_W-1:0]       = smp.sample_in;
    w_frame_in[PD_LSB +: PD_W]   = smp.pd_in;
  end

  // A strobe on the drain cycle refills the register without counting an overrun.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    if (w_drain) begin
      hold_full_d = 1'b0;
    end
    if (smp.sample_stb) begin
      hold_d      = w_frame_in;
      hold_full_d = 1'b1;
      if (hold_full_q && !w_drain && (ovr_q != c_ovr_max)) begin
        ovr_d = ovr_q + 1'b1;
      end
    end
    if (clr_ovr) begin
      ovr_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csb_d     = csb_q;
    case (state_q)
      ST_IDLE: begin
        if (w_drain) begin
          state_d   = ST_SHIFT;
          shreg_d   = hold_q[FRAME_W-2:0];
          mosi_d    = hold_q[FRAME_W-1];
          csb_d     = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (w_rise_tick) begin
          sclk_d = 1'b1;
        end
        if (w_fall_tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == c_last_bit) begin
            state_d   = ST_GAP;
            csb_d     = 1'b1;
            mosi_d    = 1'b0;
            gap_cnt_d = '0;
          end else begin
            mosi_d    = shreg_q[FRAME_W-2];
            shreg_d   = {shreg_q[FRAME_W-3:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == c_last_gap) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csb_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      csb_q       <= csb_d;
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign csb       = csb_q;
  assign busy      = (state_q != ST_IDLE);
  assign hold_full = hold_full_q;
  assign ovr_cnt   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_dac_frame_tx
// Brief   : Directed and random stimulus against a cycle-arithmetic model of the DAC TX.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dac_frame_tx;

  localparam int DATA_W    = 12;
  localparam int FRAME_W   = 16;
  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 2;
  localparam int OVR_W     = 8;
  localparam int SHIFT_LEN = 2 * CLK_DIV * FRAME_W;
  localparam int PERIOD    = 1 + SHIFT_LEN + CS_GAP;
  localparam int OVR_MAX   = (1 << OVR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr_ovr = 1'b0;
  logic             sclk, mosi, csb, busy, hold_full;
  logic [OVR_W-1:0] ovr_cnt;

  dac_frame_tx_if #(.DATA_W(DATA_W)) bus ();

  dac_frame_tx #(
    .DATA_W (DATA_W), .FRAME_W (FRAME_W), .CLK_DIV (CLK_DIV),
    .CS_GAP (CS_GAP), .OVR_W (OVR_W)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .clr_ovr (clr_ovr), .smp (bus.slave),
    .sclk (sclk), .mosi (mosi), .csb (csb), .busy (busy),
    .hold_full (hold_full), .ovr_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [FRAME_W-1:0] mkf(input logic [1:0] pd, input logic [DATA_W-1:0] s);
    return {2'b00, pd, s};
  endfunction

  // Reference model: holding register plus "engine free again PERIOD clks after a start".
  int                 cyc = 0;
  logic [FRAME_W-1:0] m_hold = '0;
  logic [FRAME_W-1:0] m_frame = '0;
  bit                 m_full = 0;
  bit                 m_drain;
  int                 m_ovr = 0;
  int                 m_start = -1000;
  int                 m_free_at = 0;
  logic [FRAME_W-1:0] exp_q[$];

  initial begin : p_model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_full = 0; m_ovr = 0; m_start = -1000; m_free_at = 0;
        exp_q.delete();
      end else begin
        m_drain = m_full && en && (cyc >= m_free_at);
        if (m_drain) begin
          m_frame   = m_hold;
          m_start   = cyc;
          m_free_at = cyc + PERIOD;
          exp_q.push_back(m_hold);
          m_full    = 0;
        end
        if (bus.sample_stb) begin
          if (m_full && m_ovr < OVR_MAX) m_ovr++;
          m_hold = mkf(bus.pd_in, bus.sample_in);
          m_full = 1;
        end
        if (clr_ovr) m_ovr = 0;
        cyc++;
      end
    end
  end

  // Per-cycle output check plus serial frame capture on the pins.
  bit                 chk_on = 0;
  bit                 e_csb, e_sclk, e_mosi, prev_sclk, prev_csb;
  int                 o, nb, hi_run, min_gap, n_frames;
  logic [FRAME_W-1:0] rx, last_rx;

  initial begin : p_monitor
    n_frames = 0; min_gap = 1000; last_rx = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        rx = '0; nb = 0; prev_sclk = 0; prev_csb = 1; hi_run = 0;
      end else begin
        if (chk_on) begin
          e_csb = 1; e_sclk = 0; e_mosi = 0;
          if (cyc > m_start && cyc <= m_start + SHIFT_LEN) begin
            o      = cyc - m_start - 1;
            e_csb  = 0;
            e_sclk = (o % (2 * CLK_DIV)) >= CLK_DIV;
            e_mosi = m_frame[FRAME_W-1-o/(2*CLK_DIV)];
          end
          chk("pins_csb_sclk_mosi", {csb, sclk, mosi}, {e_csb, e_sclk, e_mosi});
          chk("busy", busy, (cyc > m_start && cyc < m_free_at));
          chk("hold_full", hold_full, m_full);
          chk("ovr_cnt", ovr_cnt, m_ovr);
        end
        if (!csb && sclk && !prev_sclk) begin
          rx = {rx[FRAME_W-2:0], mosi};
          nb++;
        end
        if (csb) hi_run++;
        if (!csb && prev_csb) begin
          if (hi_run < min_gap) min_gap = hi_run;
          hi_run = 0;
        end
        if (csb && !prev_csb) begin
          chk("frame_bits", nb, FRAME_W);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_data", rx, exp_q.pop_front());
          last_rx = rx; n_frames++; rx = '0; nb = 0;
        end
        prev_sclk = sclk; prev_csb = csb;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [DATA_W-1:0] s, input logic [1:0] pd);
    bus.sample_in = s; bus.pd_in = pd; bus.sample_stb = 1'b1;
    step(1);
    bus.sample_stb = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      step(1);
      done = !busy && !hold_full;
    end
    chk("idle_within_budget", done, 1);
  endtask

  int f0;

  initial begin : p_stim
    bus.sample_in = '0; bus.pd_in = '0; bus.sample_stb = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_pins", {csb, sclk, mosi}, 3'b100);
    chk("rst_busy", busy, 0);
    chk("rst_hold_full", hold_full, 0);
    chk("rst_ovr", ovr_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_on = 1; en = 1'b1;
    step(3);

    // 1: single frame
    strobe(12'hA5C, 2'b00);
    chk("t1_csb_high_decide", csb, 1);
    step(1);
    chk("t1_csb_low", csb, 0);
    wait_idle(200);
    chk("t1_frame", last_rx, 16'h0A5C);

    // 2: strobes every 66 clks, back-to-back frames
    f0 = n_frames; min_gap = 1000;
    for (int i = 1; i <= 6; i++) begin
      strobe(DATA_W'(i), 2'b00);
      step(65);
    end
    wait_idle(400);
    chk("t2_frames", n_frames - f0, 6);
    chk("t2_ovr", ovr_cnt, 0);
    chk("t2_min_gap", min_gap, CS_GAP + 1);
    chk("t2_last", last_rx, 16'h0006);

    // 3: two strobes during a frame -> one overrun, newest wins
    f0 = n_frames;
    strobe(12'h111, 2'b00);
    step(10);
    strobe(12'h222, 2'b00);
    step(5);
    strobe(12'h333, 2'b00);
    wait_idle(400);
    chk("t3_ovr", ovr_cnt, 1);
    chk("t3_frames", n_frames - f0, 2);
    chk("t3_last", last_rx, 16'h0333);

    // 4: strobe on the frame-start cycle
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    f0 = n_frames;
    bus.sample_in = 12'h444; bus.pd_in = 2'b01; bus.sample_stb = 1'b1;
    step(1);
    bus.sample_in = 12'h555; bus.pd_in = 2'b10;
    step(1);
    bus.sample_stb = 1'b0;
    wait_idle(400);
    chk("t4_ovr", ovr_cnt, 0);
    chk("t4_frames", n_frames - f0, 2);
    chk("t4_last", last_rx, mkf(2'b10, 12'h555));

    // 5: saturation, clear, clear-wins
    en = 1'b0;
    bus.sample_stb = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.sample_in = DATA_W'($urandom); bus.pd_in = 2'($urandom);
      step(1);
    end
    bus.sample_stb = 1'b0;
    chk("t5_sat", ovr_cnt, OVR_MAX);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    chk("t5_clr", ovr_cnt, 0);
    strobe(12'h0F0, 2'b11);
    chk("t5_ovr_one", ovr_cnt, 1);
    bus.sample_stb = 1'b1; clr_ovr = 1'b1; step(1);
    bus.sample_stb = 1'b0; clr_ovr = 1'b0;
    chk("t5_clr_wins", ovr_cnt, 0);
    en = 1'b1;
    wait_idle(200);
    chk("t5_last", last_rx, mkf(2'b11, 12'h0F0));

    // 6: async reset mid-frame
    strobe(12'h7E1, 2'b01);
    begin
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        step(1);
        seen = (nb >= 7);
      end
      chk("t6_reached_bit7", seen, 1);
    end
    strobe(12'h123, 2'b00);
    rst = 1'b1;
    #1;
    chk("t6_rst_pins", {csb, sclk, mosi}, 3'b100);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_hold", hold_full, 0);
    step(3);
    rst = 1'b0;
    step(20);
    chk("t6_idle_csb", csb, 1);
    chk("t6_idle_busy", busy, 0);
    f0 = n_frames;
    strobe(12'h9AB, 2'b10);
    wait_idle(200);
    chk("t6_frames", n_frames - f0, 1);
    chk("t6_last", last_rx, mkf(2'b10, 12'h9AB));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.sample_stb = ($urandom_range(0, 39) == 0);
      bus.sample_in  = DATA_W'($urandom);
      bus.pd_in      = 2'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      clr_ovr = ($urandom_range(0, 299) == 0);
      step(1);
    end
    bus.sample_stb = 1'b0; clr_ovr = 1'b0; en = 1'b1;
    wait_idle(400);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
